// File: rtl/count_arbiter_pkg.sv
// Shared types and helpers for the round-robin counter arbiter.
// Holds the FSM state encoding, default sizes and the rotating-priority search.
package count_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CW_DEF   = 4;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First asserted request at or above ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [IDX_W-1:0]    ptr,
                                         input logic [NREQ_MAX-1:0] req,
                                         input int unsigned         nreq);
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            cand = IDX_W'((32'(ptr) + i) % nreq);
            if (!pick.valid && (i < nreq) && req[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/count_arbiter_if.sv
// Request/grant bus between the requesters and the counter arbiter.
// master = requester side, slave = arbiter side.
interface count_arbiter_if #(
    parameter int unsigned NREQ = count_arb_pkg::NREQ_DEF,
    parameter int unsigned CW   = count_arb_pkg::CW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      count;
    logic               busy;

    modport master (
        output req,
        output len,
        input  grant,
        input  done,
        input  count,
        input  busy
    );

    modport slave (
        input  req,
        input  len,
        output grant,
        output done,
        output count,
        output busy
    );
endinterface

// File: rtl/count_arbiter_counter_core.sv
// Shared CW-bit up-counter with synchronous clear (priority) and enable.
module counter_core #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o
);
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters,
// running it to each winner's latched terminal count and pulsing done.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input logic            clk,
    input logic            reset,
    count_arbiter_if.slave bus
);
    state_e           state_q,  state_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [IDX_W-1:0] ptr_q,    ptr_d;
    logic [CW-1:0]    tc_q,     tc_d;
    logic [NREQ-1:0]  grant_q,  grant_d;
    logic [NREQ-1:0]  done_q,   done_d;
    logic             busy_q,   busy_d;

    logic             cnt_en_c;
    logic             cnt_clr_c;
    logic [CW-1:0]    count_c;
    rr_pick_t         pick_c;
    logic [CW-1:0]    len_sel_c;
    logic             win_req_c;
    logic [IDX_W-1:0] ptr_next_c;

    assign pick_c = rr_pick(ptr_q, NREQ_MAX'(bus.req), NREQ);

    // Terminal count of the candidate winner and live request of the current winner.
    always_comb begin
        len_sel_c = '0;
        win_req_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_c.idx == IDX_W'(i)) begin
                len_sel_c = bus.len[i*CW +: CW];
            end
            if (winner_q == IDX_W'(i)) begin
                win_req_c = bus.req[i];
            end
        end
    end

    assign ptr_next_c = (winner_q >= IDX_W'(NREQ - 1)) ? '0 : winner_q + IDX_W'(1);

    counter_core #(.CW(CW)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (cnt_en_c),
        .clr_i   (cnt_clr_c),
        .count_o (count_c)
    );

    // Next-state and registered-output logic; abort outranks terminal count.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        tc_d      = tc_q;
        grant_d   = grant_q;
        done_d    = '0;
        busy_d    = busy_q;
        cnt_en_c  = 1'b0;
        cnt_clr_c = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr_c = 1'b1;
                if (pick_c.valid) begin
                    state_d  = RUN;
                    winner_d = pick_c.idx;
                    tc_d     = len_sel_c;
                    grant_d  = NREQ'(1) << pick_c.idx;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (!win_req_c) begin
                    state_d   = IDLE;
                    cnt_clr_c = 1'b1;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_next_c;
                end else if (count_c == tc_q) begin
                    state_d = DONE;
                    grant_d = '0;
                    done_d  = NREQ'(1) << winner_q;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            DONE: begin
                // Count holds tc during DONE and clears on the way back to IDLE.
                cnt_clr_c = 1'b1;
                state_d   = IDLE;
                busy_d    = 1'b0;
                ptr_d     = ptr_next_c;
            end
            default: begin
                cnt_clr_c = 1'b1;
                state_d   = IDLE;
                grant_d   = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            winner_q <= '0;
            ptr_q    <= '0;
            tc_q     <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            tc_q     <= tc_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_c;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter: a job-level model predicts grant order
// and lengths; a negedge monitor pops and checks each job as the DUT runs it.
module tb_count_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned LW = N * W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    count_arbiter_if #(.NREQ(N), .CW(W)) bus ();

    count_arbiter #(.NREQ(N), .CW(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int tc;
        bit abort;
    } job_t;

    job_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr  = 0;

    function automatic void check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: serve every requester in the mask once, rotating from m_ptr.
    function automatic void model_push(input logic [N-1:0] mask, input logic [LW-1:0] lens);
        logic [N-1:0] pend;
        pend = mask;
        while (pend != 0) begin
            for (int j = 0; j < N; j++) begin
                int w;
                w = (m_ptr + j) % N;
                if (pend[w]) begin
                    exp_q.push_back('{idx: w, tc: int'(lens[w*W +: W]), abort: 1'b0});
                    pend[w] = 1'b0;
                    m_ptr   = (w + 1) % N;
                    break;
                end
            end
        end
    endfunction

    // Monitor: tracks the current job and checks grant, count, done and busy.
    bit   in_job = 1'b0;
    job_t cur    = '{idx: -1, tc: 0, abort: 1'b0};
    int   k      = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_job = 1'b0;
        end else begin
            int eg;
            check(bus.busy == ((bus.grant != 0) || (bus.done != 0)), "busy",
                  int'(bus.busy), int'((bus.grant != 0) || (bus.done != 0)));
            check($onehot0(bus.grant) && $onehot0(bus.done), "onehot",
                  int'({bus.grant, bus.done}), 0);
            if (bus.grant != 0) begin
                if (!in_job) begin
                    check(exp_q.size() != 0, "grant_expected", int'(bus.grant), 0);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    else cur = '{idx: -1, tc: 0, abort: 1'b0};
                    in_job = 1'b1;
                    k      = 0;
                end
                eg = (cur.idx >= 0) ? (1 << cur.idx) : 0;
                check(int'(bus.grant) == eg, "grant", int'(bus.grant), eg);
                check(int'(bus.count) == k, "count", int'(bus.count), k);
                k++;
            end else if (bus.done != 0) begin
                eg = (in_job && !cur.abort && cur.idx >= 0) ? (1 << cur.idx) : 0;
                check(int'(bus.done) == eg, "done", int'(bus.done), eg);
                check(k == cur.tc + 1, "grant_len", k, cur.tc + 1);
                check(int'(bus.count) == cur.tc, "count_done", int'(bus.count), cur.tc);
                in_job = 1'b0;
            end else begin
                if (in_job) check(cur.abort, "abort_expected", 0, 1);
                check(bus.count == 0, "count_idle", int'(bus.count), 0);
                in_job = 1'b0;
            end
        end
    end

    // Requesters drop req on their own done pulse; optionally scramble the running winner's len.
    task automatic run_batch(input logic [N-1:0] mask, input logic [LW-1:0] lens, input bit chg);
        int cyc;
        cyc     = 0;
        bus.len = lens;
        model_push(mask, lens);
        bus.req = mask;
        while (bus.req != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (bus.done[i]) bus.req[i] = 1'b0;
                if (chg && bus.grant[i]) bus.len[i*W +: W] = W'($urandom);
            end
        end
        check(bus.req == 0, "batch_timeout", int'(bus.req), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic abort_test();
        logic [LW-1:0] l;
        int cyc;
        l = LW'($urandom);
        l[1*W +: W] = W'(10);
        bus.len = l;
        exp_q.push_back('{idx: 1, tc: 10, abort: 1'b1});
        bus.req = 4'b0010;
        cyc = 0;
        while (!(bus.grant == 4'b0010 && bus.count == 2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(bus.grant == 4'b0010 && bus.count == 2, "abort_setup", int'(bus.count), 2);
        bus.req = 4'b0100;
        m_ptr   = 2;
        run_batch(4'b0100, l, 1'b0);
    endtask

    task automatic reset_test();
        logic [LW-1:0] l;
        int cyc;
        l = LW'($urandom);
        l[0 +: W] = W'(12);
        bus.len = l;
        exp_q.push_back('{idx: 0, tc: 12, abort: 1'b0});
        bus.req = 4'b0001;
        cyc = 0;
        while (!(bus.grant == 4'b0001 && bus.count == 5) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(bus.grant == 4'b0001 && bus.count == 5, "reset_setup", int'(bus.count), 5);
        #2 reset = 1'b1;
        #1;
        check(bus.grant == 0, "rst_grant", int'(bus.grant), 0);
        check(bus.done == 0, "rst_done", int'(bus.done), 0);
        check(bus.count == 0, "rst_count", int'(bus.count), 0);
        check(bus.busy == 0, "rst_busy", int'(bus.busy), 0);
        bus.req = '0;
        exp_q.delete();
        m_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [N-1:0]  mask;
        logic [LW-1:0] lens;
        bus.req = '0;
        bus.len = '0;
        repeat (2) @(negedge clk);
        check(bus.grant == 0, "init_grant", int'(bus.grant), 0);
        check(bus.done == 0, "init_done", int'(bus.done), 0);
        check(bus.count == 0, "init_count", int'(bus.count), 0);
        check(bus.busy == 0, "init_busy", int'(bus.busy), 0);
        #1 reset = 1'b0;
        @(negedge clk);

        run_batch(4'b1111, 16'h1111, 1'b0);
        run_batch(4'b0001, 16'h0003, 1'b0);
        run_batch(4'b0100, 16'h0000, 1'b0);
        run_batch(4'b1000, 16'hF000, 1'b0);
        run_batch(4'b0110, 16'h0A50, 1'b1);
        abort_test();
        reset_test();

        for (int b = 0; b < 20; b++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    0:       lens[i*W +: W] = '0;
                    1:       lens[i*W +: W] = '1;
                    default: lens[i*W +: W] = W'($urandom);
                endcase
            end
            run_batch(mask, lens, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "jobs_left", exp_q.size(), 0);
        check(!in_job, "job_open", int'(in_job), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
